// File: rtl/bound_flasher_pkg.sv
// Shared phase encoding for the bound flasher lamp sequencer.
package bound_flasher_pkg;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PH_IDLE = 3'd0;
  localparam logic [PHASE_W-1:0] PH_UP1  = 3'd1;
  localparam logic [PHASE_W-1:0] PH_DN1  = 3'd2;
  localparam logic [PHASE_W-1:0] PH_UP2  = 3'd3;
  localparam logic [PHASE_W-1:0] PH_DN2  = 3'd4;
  localparam logic [PHASE_W-1:0] PH_UP3  = 3'd5;
  localparam logic [PHASE_W-1:0] PH_DN3  = 3'd6;

endpackage

// File: rtl/flasher_tick.sv
// Step prescaler: tick is high on every DIV-th cycle after the last clear.
module flasher_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bound_flasher_gen.sv
// Thermometer lamp sequencer: up/down sweeps between two bounds with flick kickback.
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int BOUND_A = 5,
  parameter int BOUND_B = 10,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flick,
  input  logic               auto_rep,
  output logic [WIDTH-1:0]   lamps,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               done
);

  if (!(BOUND_A > 0 && BOUND_A < BOUND_B && BOUND_B < WIDTH - 1 && DIV >= 1)) begin : g_param_check
    $error("bound_flasher_gen: need 0 < BOUND_A < BOUND_B < WIDTH-1 and DIV >= 1");
  end

  localparam int LW = $clog2(WIDTH + 1);

  logic [LW-1:0]      level, level_up, level_dn, level_nxt;
  logic [PHASE_W-1:0] phase_nxt;
  logic               done_nxt;
  logic               tick;
  logic               clr;
  logic               at_bound;

  // Prescaler is held cleared while idle so the first step lands DIV cycles after start.
  assign clr = (phase == PH_IDLE);

  flasher_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    level_up  = (level == LW'(WIDTH)) ? level : level + LW'(1);
    level_dn  = (level == '0) ? level : level - LW'(1);
    at_bound  = (level_up == LW'(BOUND_A + 1)) || (level_up == LW'(BOUND_B + 1));
    level_nxt = level;
    phase_nxt = phase;
    done_nxt  = 1'b0;
    case (phase)
      PH_IDLE: if (flick || auto_rep) begin
        level_nxt = LW'(1);
        phase_nxt = PH_UP1;
      end
      PH_UP1: if (tick) begin
        level_nxt = level_up;
        if (level_up == LW'(BOUND_A + 1)) phase_nxt = PH_DN1;
      end
      PH_DN1: if (tick) begin
        level_nxt = level_dn;
        if (level_dn == '0) phase_nxt = PH_UP2;
      end
      PH_UP2: if (tick) begin
        level_nxt = level_up;
        if (flick && at_bound) phase_nxt = PH_DN1;
        else if (level_up == LW'(BOUND_B + 1)) phase_nxt = PH_DN2;
      end
      PH_DN2: if (tick) begin
        level_nxt = level_dn;
        if (level_dn == LW'(BOUND_A)) phase_nxt = PH_UP3;
      end
      PH_UP3: if (tick) begin
        level_nxt = level_up;
        if (flick && at_bound) phase_nxt = PH_DN2;
        else if (level_up == LW'(WIDTH)) phase_nxt = PH_DN3;
      end
      PH_DN3: if (tick) begin
        level_nxt = level_dn;
        if (level_dn == '0) begin
          phase_nxt = PH_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        level_nxt = '0;
        phase_nxt = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      phase <= PH_IDLE;
      done  <= 1'b0;
    end else begin
      level <= level_nxt;
      phase <= phase_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    lamps = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      lamps[j] = (j < 32'(level));
    end
  end

  assign busy = (phase != PH_IDLE);

endmodule
